tdm_demux: RTL



---
 rtl/tdm_demux_pkg.sv | 19 +
 rtl/tdm_demux_ctrl.sv | 84 ++++++++
 rtl/tdm_demux.sv | 67 ++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encodings and pointer sizing.
package tdm_defs;

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_WAIT_SOF = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tdm_demux_ctrl.sv
// Framing FSM and slot pointer: decodes each valid sample into a slot write, a publish or an error.
// Purely combinational strobes from registered state; no backpressure, every valid sample is consumed.
module tdm_demux_ctrl
   import tdm_defs::*;
#(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic             in_sof_i,
   output logic [LANES-1:0] wr_en_o,
   output logic             publish_o,
   output logic             err_o,
   output logic             locked_o
);

   localparam int PW = clog2(LANES);

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HUNT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_o   = '0;
      publish_o = 1'b0;
      err_o     = 1'b0;
      locked_o  = (state_q == ST_COLLECT) || (state_q == ST_WAIT_SOF);
      if (in_valid_i) begin
         case (state_q)
            ST_HUNT: begin
               if (in_sof_i) begin
                  wr_en_o[0] = 1'b1;
                  ptr_d      = PW'(1);
                  state_d    = ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (in_sof_i) begin
                  // Early SOF: restart the frame on this sample, flag the loss.
                  err_o      = 1'b1;
                  wr_en_o[0] = 1'b1;
                  ptr_d      = PW'(1);
               end else begin
                  wr_en_o[ptr_q] = 1'b1;
                  if (ptr_q == PW'(LANES - 1)) begin
                     publish_o = 1'b1;
                     ptr_d     = '0;
                     state_d   = ST_WAIT_SOF;
                  end else begin
                     ptr_d = ptr_q + PW'(1);
                  end
               end
            end
            ST_WAIT_SOF: begin
               if (in_sof_i) begin
                  wr_en_o[0] = 1'b1;
                  ptr_d      = PW'(1);
                  state_d    = ST_COLLECT;
               end else begin
                  err_o   = 1'b1;
                  state_d = ST_HUNT;
               end
            end
            default: begin
               state_d = ST_HUNT;
               ptr_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demux: collects LANES samples into a shadow buffer and publishes whole frames.
// Frame visible one cycle after the last slot is accepted; no backpressure, accepts every valid cycle.
module tdm_demux
   import tdm_defs::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_sof,
   output logic [LANES*WIDTH-1:0] lane_data,
   output logic                   frame_valid,
   output logic                   sync_err,
   output logic                   locked
);

   logic [LANES-1:0]       wr_en;
   logic                   publish;
   logic                   err;
   logic [WIDTH-1:0]       shadow_q [LANES];
   logic [LANES*WIDTH-1:0] lane_data_q, frame_d;
   logic                   frame_valid_q;
   logic                   sync_err_q;

   tdm_demux_ctrl #(.LANES(LANES)) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .in_sof_i   (in_sof),
      .wr_en_o    (wr_en),
      .publish_o  (publish),
      .err_o      (err),
      .locked_o   (locked)
   );

   // Merge the sample being written this cycle so the final slot lands in the same publish.
   always_comb begin
      frame_d = '0;
      for (int k = 0; k < LANES; k++) begin
         frame_d[k*WIDTH +: WIDTH] = wr_en[k] ? in_data : shadow_q[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q      <= '{default: '0};
         lane_data_q   <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) shadow_q[k] <= in_data;
         end
         if (publish) lane_data_q <= frame_d;
         frame_valid_q <= publish;
         sync_err_q    <= err;
      end
   end

   assign lane_data   = lane_data_q;
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;

endmodule
